// File: rtl/sd_wb_dma_master.sv
// ----------------------------------------------------------------------------
// sd_wb_dma_master
//   Wishbone classic-cycle DMA master for the SD data path. Moves 32-bit words
//   between system memory and the SD TX/RX FIFOs. Each word is one single-beat
//   cycle; there are no bursts.
//     read  direction : memory  -> TX FIFO (card write)
//     write direction : RX FIFO -> memory  (card read)
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-low reset
//   start_rd_i / start_wr_i   1-cycle start pulses (read wins if both are high)
//   abort_i                   drop any transfer, back to IDLE on the next edge
//   dma_addr_i, word_cnt_i    start byte address / word count, sampled at start
//   m_wb_*                    Wishbone master interface
//   tx_dat_o, tx_we_o         TX FIFO push
//   rx_dat_i, rx_rd_o         RX FIFO head (FWFT) and pop
//   tx_full_i, rx_empty_i     FIFO flow control
//   busy_o, done_o, err_o     status; done_o/err_o are 1-cycle pulses
// ----------------------------------------------------------------------------
module sd_wb_dma_master #(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_rd_i,
    input  logic             start_wr_i,
    input  logic             abort_i,
    input  logic [31:0]      dma_addr_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    output logic [31:0]      m_wb_adr_o,
    output logic [31:0]      m_wb_dat_o,
    input  logic [31:0]      m_wb_dat_i,
    output logic [3:0]       m_wb_sel_o,
    output logic             m_wb_we_o,
    output logic             m_wb_cyc_o,
    output logic             m_wb_stb_o,
    input  logic             m_wb_ack_i,
    input  logic             m_wb_err_i,
    output logic [31:0]      tx_dat_o,
    output logic             tx_we_o,
    input  logic             tx_full_i,
    input  logic [31:0]      rx_dat_i,
    output logic             rx_rd_o,
    input  logic             rx_empty_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUS} state_t;

    // Timer just wide enough to hold ACK_TIMEOUT.
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_dir_q, rd_dir_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [TW-1:0]    timer_nx;
    logic             timeout;

    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [3:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic [31:0]      tx_dat_q, tx_dat_d;
    logic             tx_we_q, tx_we_d;
    logic             rx_rd_q, rx_rd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // timer_q counts completed BUS cycles without ack/err; the timeout fires
    // on the cycle whose completion would make that count reach ACK_TIMEOUT,
    // so cyc is held for exactly ACK_TIMEOUT cycles.
    assign timer_nx = timer_q + TW'(1);
    assign timeout  = (ACK_TIMEOUT > 0) && (timer_nx == TW'(ACK_TIMEOUT));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        rd_dir_d = rd_dir_q;
        timer_d  = timer_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        tx_dat_d = tx_dat_q;
        busy_d   = busy_q;
        tx_we_d  = 1'b0;
        rx_rd_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (abort_i) begin
            // Abort beats everything, including a same-cycle ack.
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = 4'h0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_rd_i || start_wr_i) begin
                        addr_d   = {dma_addr_i[31:2], 2'b00};
                        cnt_d    = word_cnt_i;
                        rd_dir_d = start_rd_i;
                        if (word_cnt_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (rd_dir_q ? !tx_full_i : !rx_empty_i) begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        sel_d   = 4'hF;
                        adr_d   = addr_q;
                        we_d    = !rd_dir_q;
                        timer_d = '0;
                        state_d = S_BUS;
                        if (!rd_dir_q) begin
                            // Word leaves the FIFO now; it is gone even if
                            // the bus cycle is later aborted.
                            dat_d   = rx_dat_i;
                            rx_rd_d = 1'b1;
                        end
                    end
                end

                S_BUS: begin
                    if (m_wb_err_i || (!m_wb_ack_i && timeout)) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        sel_d   = 4'h0;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (m_wb_ack_i) begin
                        cyc_d  = 1'b0;
                        stb_d  = 1'b0;
                        we_d   = 1'b0;
                        sel_d  = 4'h0;
                        addr_d = addr_q + 32'd4;
                        cnt_d  = cnt_q - CNT_W'(1);
                        if (rd_dir_q) begin
                            tx_we_d  = 1'b1;
                            tx_dat_d = m_wb_dat_i;
                        end
                        if (cnt_q == CNT_W'(1)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        timer_d = timer_nx;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rd_dir_q <= 1'b0;
            timer_q  <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            tx_dat_q <= '0;
            tx_we_q  <= 1'b0;
            rx_rd_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rd_dir_q <= rd_dir_d;
            timer_q  <= timer_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            tx_dat_q <= tx_dat_d;
            tx_we_q  <= tx_we_d;
            rx_rd_q  <= rx_rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign m_wb_adr_o = adr_q;
    assign m_wb_dat_o = dat_q;
    assign m_wb_sel_o = sel_q;
    assign m_wb_we_o  = we_q;
    assign m_wb_cyc_o = cyc_q;
    assign m_wb_stb_o = stb_q;
    assign tx_dat_o   = tx_dat_q;
    assign tx_we_o    = tx_we_q;
    assign rx_rd_o    = rx_rd_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_sd_wb_dma_master.sv
// Directed bench for sd_wb_dma_master: zero-wait Wishbone slave, small RX
// FIFO model and an event monitor, all sampled on the falling clock edge.
module tb_sd_wb_dma_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_rd = 1'b0, start_wr = 1'b0, abort = 1'b0;
    logic [31:0] dma_addr = '0;
    logic [15:0] word_cnt = '0;
    logic [31:0] m_wb_adr, m_wb_dat_o, tx_dat;
    logic [31:0] m_wb_dat_i = '0;
    logic [3:0]  m_wb_sel;
    logic        m_wb_we, m_wb_cyc, m_wb_stb, m_wb_ack, m_wb_err;
    logic        tx_we, rx_rd, busy, done, err;
    logic        tx_full = 1'b0;
    logic        rx_empty;
    logic [31:0] rx_dat;

    logic        ack_auto = 1'b0, err_auto = 1'b0;
    logic        ack_force = 1'b0;
    logic        ack_en = 1'b1;
    int          err_word = -1;
    int          acc_base = 0;
    logic [31:0] rd_base = '0;

    logic [31:0] rx_mem [0:15];
    logic [3:0]  rx_rp = '0, rx_wp = '0;

    logic [31:0] acc_adr [0:255];
    logic [31:0] acc_dat [0:255];
    logic        acc_we  [0:255];
    logic [3:0]  acc_sel [0:255];
    logic [31:0] tx_log  [0:255];
    int acc_n = 0, tx_n = 0, rx_pops = 0, dones = 0, errs = 0;
    int cyc_run = 0, last_run = 0, cur;
    logic cyc_prev = 1'b0;

    int n_chk = 0, n_fail = 0;

    assign m_wb_ack = ack_auto | ack_force;
    assign m_wb_err = err_auto;
    assign rx_empty = (rx_rp == rx_wp);
    assign rx_dat   = rx_mem[rx_rp];

    sd_wb_dma_master #(.ACK_TIMEOUT(8), .CNT_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .start_rd_i(start_rd), .start_wr_i(start_wr), .abort_i(abort),
        .dma_addr_i(dma_addr), .word_cnt_i(word_cnt),
        .m_wb_adr_o(m_wb_adr), .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
        .m_wb_sel_o(m_wb_sel), .m_wb_we_o(m_wb_we), .m_wb_cyc_o(m_wb_cyc),
        .m_wb_stb_o(m_wb_stb), .m_wb_ack_i(m_wb_ack), .m_wb_err_i(m_wb_err),
        .tx_dat_o(tx_dat), .tx_we_o(tx_we), .tx_full_i(tx_full),
        .rx_dat_i(rx_dat), .rx_rd_o(rx_rd), .rx_empty_i(rx_empty),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    // Monitor + zero-wait slave. A slave reply set here is seen by the DUT on
    // the following rising edge, i.e. in the first cycle stb is high.
    always @(negedge clk) begin
        if (m_wb_cyc === 1'b1 && !cyc_prev) begin
            acc_adr[acc_n] = m_wb_adr;
            acc_dat[acc_n] = m_wb_dat_o;
            acc_we[acc_n]  = m_wb_we;
            acc_sel[acc_n] = m_wb_sel;
            acc_n++;
        end
        if (m_wb_cyc !== 1'b1 && cyc_prev) last_run = cyc_run;
        cyc_run  = (m_wb_cyc === 1'b1) ? cyc_run + 1 : 0;
        cyc_prev = (m_wb_cyc === 1'b1);
        if (tx_we === 1'b1) begin tx_log[tx_n] = tx_dat; tx_n++; end
        if (rx_rd === 1'b1) begin rx_rp = rx_rp + 4'd1; rx_pops++; end
        if (done === 1'b1) dones++;
        if (err === 1'b1) errs++;
        cur        = acc_n - 1;
        m_wb_dat_i = rd_base + 32'(cur - acc_base);
        ack_auto   = (m_wb_cyc === 1'b1) && (m_wb_stb === 1'b1) && ack_en &&
                     ((cur - acc_base) != err_word);
        err_auto   = (m_wb_cyc === 1'b1) && (m_wb_stb === 1'b1) &&
                     ((cur - acc_base) == err_word);
    end

    task automatic pulse_start(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [15:0] c);
        @(negedge clk);
        start_rd = rd; start_wr = wr; dma_addr = a; word_cnt = c;
        @(negedge clk);
        start_rd = 1'b0; start_wr = 1'b0;
    endtask

    // Returns at the first falling edge showing done or err (n = cycle index
    // counted from the start edge), or after a bound.
    task automatic wait_evt(output int n);
        n = 1;
        while (!(done === 1'b1 || err === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
    endtask

    task automatic wait_cyc(output int n);
        n = 0;
        while (m_wb_cyc !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({m_wb_adr, m_wb_dat_o, m_wb_sel, m_wb_we, m_wb_cyc, m_wb_stb, tx_dat,
             tx_we, rx_rd, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got adr=%h dat=%h sel=%h cyc=%b busy=%b, required all 0",
                     m_wb_adr, m_wb_dat_o, m_wb_sel, m_wb_cyc, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read;
        int n, a0, t0, d0;
        a0 = acc_n; t0 = tx_n; d0 = dones;
        ack_en = 1'b1; err_word = -1; acc_base = acc_n; rd_base = 32'hA0;
        pulse_start(1'b1, 1'b0, 32'h0000_1000, 16'd3);
        wait_evt(n);
        n_chk++;
        if (n !== 7) begin n_fail++; $display("FAIL read_latency: got %0d cycles, required 7", n); end
        n_chk++;
        if (done !== 1'b1 || tx_we !== 1'b1 || tx_dat !== 32'hA2) begin
            n_fail++;
            $display("FAIL read_done_with_last_push: got done=%b tx_we=%b tx_dat=%h, required 1 1 000000a2",
                     done, tx_we, tx_dat);
        end
        n_chk++;
        if (acc_n - a0 !== 3 || tx_n - t0 !== 3) begin
            n_fail++;
            $display("FAIL read_counts: got acc=%0d tx=%0d, required 3 3", acc_n - a0, tx_n - t0);
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (acc_adr[a0+i] !== 32'h1000 + 32'(4*i) || acc_we[a0+i] !== 1'b0 ||
                acc_sel[a0+i] !== 4'hF || tx_log[t0+i] !== 32'hA0 + 32'(i)) begin
                n_fail++;
                $display("FAIL read_word%0d: got adr=%h we=%b sel=%h tx=%h, required adr=%h we=0 sel=f tx=%h",
                         i, acc_adr[a0+i], acc_we[a0+i], acc_sel[a0+i], tx_log[t0+i],
                         32'h1000 + 32'(4*i), 32'hA0 + 32'(i));
            end
        end
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || dones - d0 !== 1) begin
            n_fail++;
            $display("FAIL read_after: got busy=%b done=%b dones=%0d, required 0 0 1", busy, done, dones - d0);
        end
    endtask

    task automatic test_write;
        int n, a0, p0, d0;
        a0 = acc_n; p0 = rx_pops; d0 = dones;
        ack_en = 1'b1; err_word = -1; acc_base = acc_n;
        rx_mem[rx_wp] = 32'h1122_3344; rx_wp = rx_wp + 4'd1;
        pulse_start(1'b0, 1'b1, 32'h0000_2000, 16'd2);
        n = 0;
        while (rx_pops == p0 && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (m_wb_cyc !== 1'b0 || rx_rd !== 1'b0) begin
                n_fail++;
                $display("FAIL write_wait_empty%0d: got cyc=%b rx_rd=%b, required 0 0", i, m_wb_cyc, rx_rd);
            end
        end
        rx_mem[rx_wp] = 32'h5566_7788; rx_wp = rx_wp + 4'd1;
        wait_evt(n);
        n_chk++;
        if (done !== 1'b1 || rx_pops - p0 !== 2 || acc_n - a0 !== 2) begin
            n_fail++;
            $display("FAIL write_counts: got done=%b pops=%0d acc=%0d, required 1 2 2",
                     done, rx_pops - p0, acc_n - a0);
        end
        n_chk++;
        if (acc_adr[a0] !== 32'h2000 || acc_dat[a0] !== 32'h1122_3344 || acc_we[a0] !== 1'b1 ||
            acc_adr[a0+1] !== 32'h2004 || acc_dat[a0+1] !== 32'h5566_7788 || acc_we[a0+1] !== 1'b1) begin
            n_fail++;
            $display("FAIL write_data: got %h@%h we=%b, %h@%h we=%b, required 11223344@2000, 55667788@2004 we=1",
                     acc_dat[a0], acc_adr[a0], acc_we[a0], acc_dat[a0+1], acc_adr[a0+1], acc_we[a0+1]);
        end
        n_chk++;
        if (dones - d0 !== 1) begin n_fail++; $display("FAIL write_done_cnt: got %0d, required 1", dones - d0); end
    endtask

    task automatic test_tx_full;
        int n, a0, t0;
        a0 = acc_n; t0 = tx_n;
        ack_en = 1'b1; err_word = -1; acc_base = acc_n; rd_base = 32'hB0;
        tx_full = 1'b1;
        pulse_start(1'b1, 1'b0, 32'h0000_5000, 16'd2);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (m_wb_stb !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL full_hold%0d: got stb=%b busy=%b, required 0 1", i, m_wb_stb, busy);
            end
            @(negedge clk);
        end
        tx_full = 1'b0;
        wait_evt(n);
        n_chk++;
        if (done !== 1'b1 || tx_n - t0 !== 2 || acc_n - a0 !== 2 ||
            acc_adr[a0+1] !== 32'h5004 || tx_log[t0+1] !== 32'hB1) begin
            n_fail++;
            $display("FAIL full_complete: got done=%b tx=%0d acc=%0d adr1=%h tx1=%h, required 1 2 2 00005004 000000b1",
                     done, tx_n - t0, acc_n - a0, acc_adr[a0+1], tx_log[t0+1]);
        end
    endtask

    task automatic test_timeout;
        int n, t0, d0, e0;
        t0 = tx_n; d0 = dones; e0 = errs;
        ack_en = 1'b0; err_word = -1; acc_base = acc_n;
        pulse_start(1'b1, 1'b0, 32'h0000_3000, 16'd2);
        wait_evt(n);
        n_chk++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || m_wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flags: got err=%b done=%b busy=%b cyc=%b, required 1 0 0 0", err, done, busy, m_wb_cyc);
        end
        n_chk++;
        if (last_run !== 8) begin n_fail++; $display("FAIL timeout_cyc_len: got %0d cycles, required 8", last_run); end
        n_chk++;
        if (tx_n - t0 !== 0 || dones - d0 !== 0 || errs - e0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_counts: got tx=%0d done=%0d err=%0d, required 0 0 1", tx_n - t0, dones - d0, errs - e0);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_bus_err;
        int n, a0, t0, d0, e0;
        a0 = acc_n; t0 = tx_n; d0 = dones; e0 = errs;
        ack_en = 1'b1; acc_base = acc_n; err_word = 1; rd_base = 32'hD0;
        pulse_start(1'b1, 1'b0, 32'h0000_3100, 16'd4);
        wait_evt(n);
        n_chk++;
        if (err !== 1'b1 || busy !== 1'b0 || m_wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL buserr_flags: got err=%b busy=%b cyc=%b, required 1 0 0", err, busy, m_wb_cyc);
        end
        n_chk++;
        if (acc_n - a0 !== 2 || tx_n - t0 !== 1 || dones - d0 !== 0 || errs - e0 !== 1) begin
            n_fail++;
            $display("FAIL buserr_counts: got acc=%0d tx=%0d done=%0d err=%0d, required 2 1 0 1",
                     acc_n - a0, tx_n - t0, dones - d0, errs - e0);
        end
        err_word = -1;
    endtask

    task automatic test_abort;
        int n, t0, d0, e0, a0;
        t0 = tx_n; d0 = dones; e0 = errs;
        ack_en = 1'b0; err_word = -1; acc_base = acc_n;
        pulse_start(1'b1, 1'b0, 32'h0000_6000, 16'd4);
        wait_cyc(n);
        ack_force = 1'b1; abort = 1'b1;
        @(negedge clk);
        ack_force = 1'b0; abort = 1'b0;
        n_chk++;
        if (m_wb_cyc !== 1'b0 || m_wb_stb !== 1'b0 || busy !== 1'b0 || tx_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_now: got cyc=%b stb=%b busy=%b tx_we=%b, required 0 0 0 0", m_wb_cyc, m_wb_stb, busy, tx_we);
        end
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (tx_n - t0 !== 0 || dones - d0 !== 0 || errs - e0 !== 0 || m_wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: got tx=%0d done=%0d err=%0d cyc=%b, required 0 0 0 0",
                     tx_n - t0, dones - d0, errs - e0, m_wb_cyc);
        end
        a0 = acc_n; t0 = tx_n;
        ack_en = 1'b1; acc_base = acc_n; rd_base = 32'hC0;
        pulse_start(1'b1, 1'b0, 32'h0000_6100, 16'd1);
        wait_evt(n);
        n_chk++;
        if (done !== 1'b1 || tx_n - t0 !== 1 || tx_log[t0] !== 32'hC0 || acc_adr[a0] !== 32'h6100) begin
            n_fail++;
            $display("FAIL abort_restart: got done=%b tx=%0d data=%h adr=%h, required 1 1 000000c0 00006100",
                     done, tx_n - t0, tx_log[t0], acc_adr[a0]);
        end
    endtask

    task automatic test_zero_and_wrap;
        int n, a0;
        a0 = acc_n;
        ack_en = 1'b1; err_word = -1; acc_base = acc_n;
        pulse_start(1'b0, 1'b1, 32'h0000_9000, 16'd0);
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_cnt_done: got done=%b busy=%b, required 1 0", done, busy);
        end
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (done !== 1'b0 || acc_n - a0 !== 0) begin
            n_fail++;
            $display("FAIL zero_cnt_nocyc: got done=%b acc=%0d, required 0 0", done, acc_n - a0);
        end
        a0 = acc_n; acc_base = acc_n; rd_base = 32'hE0;
        pulse_start(1'b1, 1'b0, 32'hFFFF_FFFE, 16'd2);
        wait_evt(n);
        n_chk++;
        if (done !== 1'b1 || acc_n - a0 !== 2 || acc_adr[a0] !== 32'hFFFF_FFFC || acc_adr[a0+1] !== 32'h0) begin
            n_fail++;
            $display("FAIL addr_wrap: got done=%b acc=%0d adr0=%h adr1=%h, required 1 2 fffffffc 00000000",
                     done, acc_n - a0, acc_adr[a0], acc_adr[a0+1]);
        end
    endtask

    task automatic test_back_to_back;
        int n, a0, t0;
        a0 = acc_n; t0 = tx_n;
        ack_en = 1'b1; err_word = -1; acc_base = acc_n; rd_base = 32'hF0;
        // RX FIFO is empty here, so picking the write direction would stall.
        pulse_start(1'b1, 1'b1, 32'h0000_7000, 16'd1);
        wait_evt(n);
        n_chk++;
        if (done !== 1'b1 || acc_we[a0] !== 1'b0 || tx_n - t0 !== 1 || tx_log[t0] !== 32'hF0) begin
            n_fail++;
            $display("FAIL both_starts_read: got done=%b we=%b tx=%0d data=%h, required 1 0 1 000000f0",
                     done, acc_we[a0], tx_n - t0, tx_log[t0]);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        ack_en = 1'b0; err_word = -1; acc_base = acc_n;
        pulse_start(1'b1, 1'b0, 32'h0000_8000, 16'd2);
        wait_cyc(n);
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({m_wb_adr, m_wb_dat_o, m_wb_sel, m_wb_we, m_wb_cyc, m_wb_stb, tx_dat,
             tx_we, rx_rd, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_bus: got adr=%h sel=%h cyc=%b stb=%b busy=%b, required all 0",
                     m_wb_adr, m_wb_sel, m_wb_cyc, m_wb_stb, busy);
        end
        rst_n = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rx_mem[i] = '0;
        test_reset();
        test_read();
        test_write();
        test_tx_full();
        test_timeout();
        test_bus_err();
        test_abort();
        test_zero_and_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
